// File: rtl/uart_rx_dma_sequencer.sv
// Drains the UART RX FIFO into word-addressed BRAM: packs bytes little-endian into
// 32-bit words and writes each word through a req/grant bus handshake.
module uart_rx_dma_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int COUNT_W = 6
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Start,
  input  logic [ADDR_W-1:0] i_Base_Addr,
  input  logic [COUNT_W-1:0] i_Byte_Count,
  input  logic              i_Fifo_Empty,
  input  logic [7:0]        i_Fifo_Byte,
  output logic              o_Read_Flag,
  output logic              o_Bus_Req,
  input  logic              i_Bus_Grant,
  output logic              o_Wr_En,
  output logic [ADDR_W-1:0] o_Wr_Addr,
  output logic [31:0]       o_Wr_Data,
  output logic [3:0]        o_Wr_Strb,
  output logic              o_Busy,
  output logic              o_Done,
  output logic [2:0]        o_State
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]  ADDR_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [1:0]         lane_idx_q, lane_idx_d;
  logic [31:0]        pack_q, pack_d;
  logic [3:0]         strb_q, strb_d;

  logic pop_s;
  logic write_s;
  logic unused_addr_lsbs_s;

  // The low address bits are forced to zero, so they are intentionally dropped.
  assign unused_addr_lsbs_s = ^i_Base_Addr[1:0];

  assign pop_s   = (state_q == ST_FETCH) && !i_Fifo_Empty;
  assign write_s = (state_q == ST_WRITE) && i_Bus_Grant;

  // Next-state and datapath update for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    lane_idx_d  = lane_idx_q;
    pack_d      = pack_q;
    strb_d      = strb_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          addr_d      = {i_Base_Addr[ADDR_W-1:2], 2'b00};
          remaining_d = i_Byte_Count;
          lane_idx_d  = 2'd0;
          pack_d      = 32'h0000_0000;
          strb_d      = 4'b0000;
          if (i_Byte_Count == CNT_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (pop_s) begin
          pack_d[{lane_idx_q, 3'b000} +: 8] = i_Fifo_Byte;
          strb_d[lane_idx_q]                = 1'b1;
          lane_idx_d  = lane_idx_q + 2'd1;
          remaining_d = remaining_q - CNT_ONE;
          // A word is ready once lane 3 fills or the last byte of the transfer lands.
          if ((lane_idx_q == 2'd3) || (remaining_q == CNT_ONE)) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_REQ: begin
        if (i_Bus_Grant) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WRITE: begin
        if (write_s) begin
          addr_d     = addr_q + ADDR_STEP;
          pack_d     = 32'h0000_0000;
          strb_d     = 4'b0000;
          lane_idx_d = 2'd0;
          if (remaining_q == CNT_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      remaining_q <= CNT_ZERO;
      lane_idx_q  <= 2'd0;
      pack_q      <= 32'h0000_0000;
      strb_q      <= 4'b0000;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      lane_idx_q  <= lane_idx_d;
      pack_q      <= pack_d;
      strb_q      <= strb_d;
    end
  end

  // Output decode; write-side buses are only driven while in WRITE.
  always_comb begin
    o_Read_Flag = pop_s;
    o_Wr_En     = write_s;
    o_Bus_Req   = 1'b0;
    o_Wr_Addr   = {ADDR_W{1'b0}};
    o_Wr_Data   = 32'h0000_0000;
    o_Wr_Strb   = 4'b0000;
    o_Done      = 1'b0;
    o_Busy      = (state_q != ST_IDLE);
    o_State     = state_q;
    case (state_q)
      ST_REQ: begin
        o_Bus_Req = 1'b1;
      end
      ST_WRITE: begin
        o_Bus_Req = 1'b1;
        o_Wr_Addr = addr_q;
        o_Wr_Data = pack_q;
        o_Wr_Strb = strb_q;
      end
      ST_DONE: begin
        o_Done = 1'b1;
      end
      default: begin
        o_Bus_Req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_dma_sequencer.sv
// Self-checking bench: FIFO and arbiter are modelled with queues; expected BRAM writes
// and latencies are derived from the byte stream, base address and count.
module tb_uart_rx_dma_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, empty, grant;
  logic [31:0] base_a;
  logic [5:0]  cnt;
  logic [7:0]  fbyte;
  logic        rd, req, wr_en, busy, done;
  logic [31:0] wa, wd;
  logic [3:0]  ws;
  logic [2:0]  st;

  int checks = 0;
  int failures = 0;

  logic [7:0]  src_q[$];
  logic [7:0]  fifo_q[$];
  logic [31:0] oa_q[$];
  logic [31:0] od_q[$];
  logic [3:0]  os_q[$];
  int r_pops, r_dones, r_done_cyc, r_viol, r_idle, r_rstate7, r_timeout;

  uart_rx_dma_sequencer #(.ADDR_W(32), .COUNT_W(6)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start), .i_Base_Addr(base_a),
    .i_Byte_Count(cnt), .i_Fifo_Empty(empty), .i_Fifo_Byte(fbyte),
    .o_Read_Flag(rd), .o_Bus_Req(req), .i_Bus_Grant(grant), .o_Wr_En(wr_en),
    .o_Wr_Addr(wa), .o_Wr_Data(wd), .o_Wr_Strb(ws), .o_Busy(busy),
    .o_Done(done), .o_State(st)
  );

  always #5 clk = ~clk;

  // Expected writes straight from the byte stream: word k covers bytes 4k..4k+3.
  function automatic int wr_mismatch(input logic [31:0] b, input int n);
    int m;
    int nwords;
    logic [31:0] a, d;
    logic [3:0] s;
    m = 0;
    nwords = (n + 3) / 4;
    if (oa_q.size() != nwords) return 1000 + oa_q.size();
    for (int k = 0; k < nwords; k++) begin
      a = (b & 32'hFFFF_FFFC) + 32'(4 * k);
      d = 32'h0;
      s = 4'h0;
      for (int j = 0; j < 4; j++) begin
        if (4 * k + j < n) begin
          d[8*j +: 8] = src_q[4*k+j];
          s[j] = 1'b1;
        end
      end
      if (oa_q[k] !== a || od_q[k] !== d || os_q[k] !== s) m++;
    end
    return m;
  endfunction

  // gmode: 0 grant tied high, 1 scripted withhold/drop, 2 random grant.
  task automatic run(input logic [31:0] b, input int n, input int gap, input int gmode);
    int avail, reqc, last_wr, need;
    fifo_q = src_q;
    fifo_q.push_back(8'($urandom));
    fifo_q.push_back(8'($urandom));
    oa_q.delete(); od_q.delete(); os_q.delete();
    r_pops = 0; r_dones = 0; r_done_cyc = -1; r_viol = 0; r_idle = 0;
    r_rstate7 = -1; r_timeout = 0;
    avail = 0; reqc = 0; last_wr = 0;
    @(negedge clk);
    start = 1'b1; base_a = b; cnt = n[5:0]; empty = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      start = 1'b0;
      base_a = $urandom;
      cnt = 6'($urandom);
      empty = (fifo_q.size() == 0) || (avail < gap);
      fbyte = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
      case (gmode)
        0: grant = 1'b1;
        1: grant = (reqc == 5) || (reqc >= 7);
        default: grant = 1'($urandom_range(0, 1));
      endcase
      #1;
      need = (4 * (oa_q.size() + 1) < n) ? 4 * (oa_q.size() + 1) : n;
      if (rd && empty) r_viol++;
      if (wr_en && !grant) r_viol++;
      if (req && r_pops < need) r_viol++;
      if (last_wr && req) r_viol++;
      if (gmode == 1 && req && reqc == 7) r_rstate7 = int'(st);
      last_wr = int'(wr_en);
      if (rd) begin
        r_pops++;
        void'(fifo_q.pop_front());
        avail = 0;
      end else begin
        avail++;
      end
      if (wr_en) begin
        oa_q.push_back(wa); od_q.push_back(wd); os_q.push_back(ws);
      end
      if (req) reqc++;
      if (done) begin
        r_dones++;
        if (r_done_cyc < 0) r_done_cyc = c;
      end
      if (r_done_cyc >= 0 && c == r_done_cyc + 2) begin
        r_idle = int'(busy == 1'b0 && st == 3'd0 && done == 1'b0);
        break;
      end
    end
    if (r_done_cyc < 0) r_timeout = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; base_a = 32'h1234_5678; cnt = 6'd5;
    empty = 1'b0; fbyte = 8'h55; grant = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({rd, req, wr_en, wa, wd, ws, busy, done, st} !== 75'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rd=%0b req=%0b we=%0b busy=%0b done=%0b st=%0d, want all 0",
               rd, req, wr_en, busy, done, st);
    end
    checks++;
    if (st !== 3'd0) begin
      failures++;
      $display("FAIL start_vs_reset: state=%0d want 0", st);
    end
    rst = 1'b0; start = 1'b0; empty = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_two_bytes();
    src_q = '{8'hC9, 8'h05};
    run(32'h0000_0100, 2, 0, 0);
    checks++;
    if (r_pops != 2) begin failures++; $display("FAIL t1_pops: got %0d want 2", r_pops); end
    checks++;
    if (oa_q.size() != 1 || oa_q[0] !== 32'h100 || od_q[0] !== 32'h0000_05C9 || os_q[0] !== 4'b0011) begin
      failures++;
      $display("FAIL t1_write: n=%0d addr=%h data=%h strb=%b want 1 write 00000100/000005c9/0011",
               oa_q.size(), (oa_q.size() != 0) ? oa_q[0] : 32'h0, (od_q.size() != 0) ? od_q[0] : 32'h0,
               (os_q.size() != 0) ? os_q[0] : 4'h0);
    end
    checks++;
    if (r_dones != 1 || r_done_cyc != 5 || r_idle != 1) begin
      failures++;
      $display("FAIL t1_done: dones=%0d cyc=%0d idle=%0d want 1/5/1", r_dones, r_done_cyc, r_idle);
    end
  endtask

  task automatic test_six_bytes();
    src_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    run(32'h0000_0100, 6, 0, 0);
    checks++;
    if (oa_q.size() != 2 || oa_q[0] !== 32'h100 || od_q[0] !== 32'h1413_1211 || os_q[0] !== 4'b1111 ||
        oa_q[1] !== 32'h104 || od_q[1] !== 32'h0000_1615 || os_q[1] !== 4'b0011) begin
      failures++;
      $display("FAIL t2_writes: got %0d writes, mismatch=%0d want 2 matching", oa_q.size(),
               wr_mismatch(32'h100, 6));
    end
    checks++;
    if (r_pops != 6 || r_dones != 1 || r_done_cyc != 11 || r_viol != 0) begin
      failures++;
      $display("FAIL t2_flow: pops=%0d dones=%0d cyc=%0d viol=%0d want 6/1/11/0",
               r_pops, r_dones, r_done_cyc, r_viol);
    end
  endtask

  task automatic test_slow_fifo();
    src_q.delete();
    for (int i = 0; i < 4; i++) src_q.push_back(8'($urandom));
    run(32'h0000_2000, 4, 10, 0);
    checks++;
    if (r_viol != 0 || r_pops != 4) begin
      failures++;
      $display("FAIL t3_handshake: viol=%0d pops=%0d want 0/4", r_viol, r_pops);
    end
    checks++;
    if (wr_mismatch(32'h2000, 4) != 0 || r_dones != 1) begin
      failures++;
      $display("FAIL t3_write: mismatch=%0d dones=%0d want 0/1", wr_mismatch(32'h2000, 4), r_dones);
    end
  endtask

  task automatic test_grant_stall();
    src_q.delete();
    for (int i = 0; i < 4; i++) src_q.push_back(8'($urandom));
    run(32'h0000_0040, 4, 0, 1);
    checks++;
    if (oa_q.size() != 1 || wr_mismatch(32'h40, 4) != 0) begin
      failures++;
      $display("FAIL t4_write: writes=%0d mismatch=%0d want 1/0", oa_q.size(), wr_mismatch(32'h40, 4));
    end
    checks++;
    if (r_rstate7 != 2 || r_viol != 0 || r_done_cyc != 14) begin
      failures++;
      $display("FAIL t4_stall: state_after_drop=%0d viol=%0d cyc=%0d want 2/0/14",
               r_rstate7, r_viol, r_done_cyc);
    end
  endtask

  task automatic test_zero_and_wrap();
    src_q.delete();
    run(32'h0000_0100, 0, 0, 0);
    checks++;
    if (r_pops != 0 || oa_q.size() != 0 || r_dones != 1 || r_done_cyc != 1 || r_idle != 1) begin
      failures++;
      $display("FAIL t5_zero: pops=%0d writes=%0d dones=%0d cyc=%0d idle=%0d want 0/0/1/1/1",
               r_pops, oa_q.size(), r_dones, r_done_cyc, r_idle);
    end
    for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom));
    run(32'hFFFF_FFFE, 8, 0, 0);
    checks++;
    if (oa_q.size() != 2 || oa_q[0] !== 32'hFFFF_FFFC || oa_q[1] !== 32'h0000_0000 ||
        wr_mismatch(32'hFFFF_FFFE, 8) != 0 || r_done_cyc != 13) begin
      failures++;
      $display("FAIL t5_wrap: writes=%0d mismatch=%0d cyc=%0d want 2 at fffffffc,00000000 / 0 / 13",
               oa_q.size(), wr_mismatch(32'hFFFF_FFFE, 8), r_done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int pops;
    bit hit;
    pops = 0;
    hit = 1'b0;
    @(negedge clk);
    start = 1'b1; base_a = 32'h0000_0200; cnt = 6'd6; empty = 1'b1; grant = 1'b1;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      empty = 1'b0;
      fbyte = 8'($urandom);
      #1;
      if (rd) pops++;
      if (pops == 2) hit = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1; empty = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (!hit || {rd, req, wr_en, wa, wd, ws, busy, done, st} !== 75'd0) begin
      failures++;
      $display("FAIL t6_reset_mid: hit=%0b busy=%0b done=%0b st=%0d req=%0b want all 0",
               hit, busy, done, st, req);
    end
    src_q = '{8'hAA};
    run(32'h0000_0300, 1, 0, 0);
    checks++;
    if (oa_q.size() != 1 || od_q[0] !== 32'h0000_00AA || os_q[0] !== 4'b0001 || r_dones != 1) begin
      failures++;
      $display("FAIL t6_restart: writes=%0d data=%h strb=%b dones=%0d want 1/000000aa/0001/1",
               oa_q.size(), (od_q.size() != 0) ? od_q[0] : 32'h0, (os_q.size() != 0) ? os_q[0] : 4'h0,
               r_dones);
    end
  endtask

  task automatic test_random();
    logic [31:0] b;
    int n, gap, gmode, exp_cyc;
    for (int it = 0; it < 20; it++) begin
      b = $urandom;
      n = $urandom_range(0, 63);
      gap = $urandom_range(0, 2);
      gmode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      src_q.delete();
      for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
      run(b, n, gap, gmode);
      checks++;
      if (r_timeout != 0 || wr_mismatch(b, n) != 0 || r_pops != n || r_dones != 1 ||
          r_viol != 0 || r_idle != 1) begin
        failures++;
        $display("FAIL rand_%0d: base=%h n=%0d to=%0d mismatch=%0d pops=%0d dones=%0d viol=%0d idle=%0d",
                 it, b, n, r_timeout, wr_mismatch(b, n), r_pops, r_dones, r_viol, r_idle);
      end
      if (gmode == 0 && gap == 0) begin
        exp_cyc = n + 2 * ((n + 3) / 4) + 1;
        checks++;
        if (r_done_cyc != exp_cyc) begin
          failures++;
          $display("FAIL rand_latency_%0d: got %0d want %0d", it, r_done_cyc, exp_cyc);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_a = 32'h0; cnt = 6'd0;
    empty = 1'b1; fbyte = 8'h00; grant = 1'b0;
    test_reset();
    test_two_bytes();
    test_six_bytes();
    test_slow_fifo();
    test_grant_stall();
    test_zero_and_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
